mult_datapath: RTL and testbench

//   Datapath for the shift-and-add multiplier; downstream partner of the CONTROL FSM.
//   - Consumes CONTROL's Load/Ad/Sh strobes.
//   - Returns M (current multiplier LSB) and K (last-shift flag) to CONTROL.
//   - Holds the accumulator/multiplier register, multiplicand register and shift counter.
//   - After N add/shift iterations, Product = Mplier * Mcand (unsigned).

---
 rtl/mult_datapath.sv | 93 +++++++++
 tb/tb_mult_datapath.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: accumulator/multiplier, multiplicand, shift counter.
// Optional completed-product holding register enabled by defining MULT_DP_PROD_HOLD_EN.
module mult_datapath #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic [N-1:0]   Mplier,
    input  logic [N-1:0]   Mcand,
    output logic           M,
    output logic           K,
`ifdef MULT_DP_PROD_HOLD_EN
    output logic [2*N-1:0] ProdHold,
    output logic           PValid,
`endif
    output logic [2*N-1:0] Product
);

    logic [2*N:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    sum;

    // Upper half plus multiplicand, carry kept in the top bit
    assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};

    // Next-state selection; Load wins over Ad/Sh, Ad+Sh adds then shifts
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (Load) begin
            acc_d   = {1'b0, {N{1'b0}}, Mplier};
            mcand_d = Mcand;
            cnt_d   = '0;
        end else if (Ad && Sh) begin
            acc_d = {1'b0, sum, acc_q[N-1:1]};
            cnt_d = cnt_q + CW'(1);
        end else if (Ad) begin
            acc_d = {sum, acc_q[N-1:0]};
        end else if (Sh) begin
            acc_d = {1'b0, acc_q[2*N:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign M       = acc_q[0];
    assign K       = (cnt_q == CW'(N - 1));
    assign Product = acc_q[2*N-1:0];

`ifdef MULT_DP_PROD_HOLD_EN
    logic [2*N-1:0] hold_q;
    logic           pvalid_q;
    logic           done;

    // Final shift happens on a Sh edge with K set, unless Load pre-empts it
    assign done = Sh && K && !Load;

    // Capture the finished product and pulse valid for one cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            pvalid_q <= done;
            if (done) begin
                hold_q <= acc_d[2*N-1:0];
            end
        end
    end

    assign ProdHold = hold_q;
    assign PValid   = pvalid_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed-vector bench for mult_datapath (N=4).
// Hold-register checks compile in when MULT_DP_PROD_HOLD_EN is defined.
module tb_mult_datapath;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           Load = 1'b0;
    logic           Ad = 1'b0;
    logic           Sh = 1'b0;
    logic [N-1:0]   Mplier = '0;
    logic [N-1:0]   Mcand = '0;
    logic           M;
    logic           K;
    logic [2*N-1:0] Product;
`ifdef MULT_DP_PROD_HOLD_EN
    logic [2*N-1:0] ProdHold;
    logic           PValid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mult_datapath #(.N(N)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Mplier  (Mplier),
        .Mcand   (Mcand),
        .M       (M),
        .K       (K),
`ifdef MULT_DP_PROD_HOLD_EN
        .ProdHold(ProdHold),
        .PValid  (PValid),
`endif
        .Product (Product)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ld, input logic ad, input logic sh,
                       input logic [N-1:0] mp, input logic [N-1:0] mc);
        Load   = ld;
        Ad     = ad;
        Sh     = sh;
        Mplier = mp;
        Mcand  = mc;
        @(posedge Clk);
        #1;
        Load = 1'b0;
        Ad   = 1'b0;
        Sh   = 1'b0;
    endtask

    initial begin
        logic [3:0] bits;

        // 1: reset with idle strobes, then hold
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        Rst = 1'b0;
        check("rst_M", 32'(M), 32'd0);
        check("rst_K", 32'(K), 32'd0);
        check("rst_P", 32'(Product), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("idle_P", 32'(Product), 32'd0);
        check("idle_K", 32'(K), 32'd0);

        // 2: 11*13, separate Ad and Sh cycles
        cyc(1'b1, 1'b0, 1'b0, 4'd11, 4'd13);
        check("c2_load_P", 32'(Product), 32'h0B);
        check("c2_load_K", 32'(K), 32'd0);
        check("c2_M0", 32'(M), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("c2_ad1_P", 32'(Product), 32'hDB);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check("c2_sh1_P", 32'(Product), 32'h6D);
        check("c2_M1", 32'(M), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("c2_ad2_P", 32'(Product), 32'h3D);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check("c2_sh2_P", 32'(Product), 32'h9E);
        check("c2_M2", 32'(M), 32'd0);
        check("c2_K2", 32'(K), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check("c2_sh3_P", 32'(Product), 32'h4F);
        check("c2_M3", 32'(M), 32'd1);
        check("c2_K3", 32'(K), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("c2_ad4_K", 32'(K), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check("c2_P", 32'(Product), 32'd143);
        check("c2_K_end", 32'(K), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("c2_hold_P", 32'(Product), 32'd143);

        // 3: 15*15 with combined Ad+Sh; strobes on Load cycle ignored
        cyc(1'b1, 1'b1, 1'b1, 4'd15, 4'd15);
        check("c3_load_P", 32'(Product), 32'h0F);
        check("c3_load_K", 32'(K), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        check("c3_e1_P", 32'(Product), 32'h7F);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        check("c3_e2_P", 32'(Product), 32'hB7);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        check("c3_e3_P", 32'(Product), 32'hD3);
        check("c3_e3_K", 32'(K), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        check("c3_P", 32'(Product), 32'd225);
        check("c3_K_end", 32'(K), 32'd0);

        // 4: 0*9, shifts only
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
        for (int i = 0; i < 4; i++) begin
            check("c4_M", 32'(M), 32'd0);
            cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        end
        check("c4_P", 32'(Product), 32'd0);
        check("c4_M_end", 32'(M), 32'd0);

        // 5: reset mid-operation, then 3*5
        cyc(1'b1, 1'b0, 1'b0, 4'd11, 4'd13);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check("c5_pre_P", 32'(Product), 32'h9E);
        Rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 4'd7, 4'd7);
        Rst = 1'b0;
        check("c5_rst_P", 32'(Product), 32'd0);
        check("c5_rst_K", 32'(K), 32'd0);
        check("c5_rst_M", 32'(M), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("c5_rst_mc", 32'(Product), 32'd0);
        bits = 4'd3;
        cyc(1'b1, 1'b0, 1'b0, 4'd3, 4'd5);
        for (int i = 0; i < 4; i++) begin
            check("c5_M", 32'(M), 32'(bits[i]));
            check("c5_K", 32'(K), (i == 3) ? 32'd1 : 32'd0);
            cyc(1'b0, bits[i], 1'b1, 4'd0, 4'd0);
        end
        check("c5_P", 32'(Product), 32'd15);

`ifdef MULT_DP_PROD_HOLD_EN
        // 6: hold register across a following run
        bits = 4'd11;
        cyc(1'b1, 1'b0, 1'b0, 4'd11, 4'd13);
        for (int i = 0; i < 4; i++) begin
            check("c6_pv_low", 32'(PValid), 32'd0);
            cyc(1'b0, bits[i], 1'b1, 4'd0, 4'd0);
        end
        check("c6_pv", 32'(PValid), 32'd1);
        check("c6_hold", 32'(ProdHold), 32'd143);
        bits = 4'd2;
        cyc(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        check("c6_pv_off", 32'(PValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("c6_keep", 32'(ProdHold), 32'd143);
            cyc(1'b0, bits[i], 1'b1, 4'd0, 4'd0);
        end
        check("c6_pv2", 32'(PValid), 32'd1);
        check("c6_hold2", 32'(ProdHold), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("c6_pv2_off", 32'(PValid), 32'd0);
        check("c6_hold2_k", 32'(ProdHold), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
